sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single off-chip 16-bit SRAM between NUM_REQ requesters: 0 = game-logic/trail access, 1 = background loader, 2 = spare.
- Each requester supplies req/we/addr/wdata and gets a one-cycle done pulse; this done drives the loaders' SRAM_done inputs.
- Owns the SRAM strobes, the address bus and the tristate data enable.
- Sits between the loader/game logic and the top-level SRAM pins.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- WAIT_CYCLES, 2, cycles strobes are held in ACCESS (1..7).

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester access request, level
- we  in  NUM_REQ  1 = write, 0 = read, per requester
- addr  in  NUM_REQ x 20  word address per requester
- wdata  in  NUM_REQ x 16  write data per requester
- done  out  NUM_REQ  one-cycle completion pulse per requester
- rdata  out  16  read data, valid from the done cycle until the next capture
- grant  out  NUM_REQ  one-hot, owner of the current access
- busy  out  1  access in progress
- SRAM_ADDR  out  20  SRAM address
- Data_to_SRAM  out  16  write data to pad
- Data_from_SRAM  in  16  pad read data
- SRAM_DQ_OE  out  1  tristate enable for Data_to_SRAM
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low strobes

Behaviour:
- Reset (async, Reset_n=0) forces:
  - state IDLE
  - CE_N/OE_N/WE_N/UB_N/LB_N = 1
  - SRAM_DQ_OE = 0
  - grant = 0, done = 0, busy = 0
  - rdata = 0, SRAM_ADDR = 0, Data_to_SRAM = 0
- Reset mid-access aborts the access with no done pulse; the requester re-requests.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req is high, select a winner (fixed priority: lowest index wins).
  - Register grant, we, addr and wdata of the winner; go to SETUP. busy = 1 from SETUP through DONE.
- SETUP:
  - Drive SRAM_ADDR. CE_N = UB_N = LB_N = 0.
  - Read: OE_N = 0. Write: SRAM_DQ_OE = 1 with Data_to_SRAM valid.
  - Load the wait counter with WAIT_CYCLES-1. Go to ACCESS.
- ACCESS:
  - Hold address and CE_N. Write: WE_N = 0. Read: OE_N = 0.
  - Counter decrements; when it reaches 0, go to DONE.
  - Read: capture Data_from_SRAM into rdata on the ACCESS->DONE edge.
- DONE:
  - WE_N = 1 (write data still driven this cycle for hold time); OE_N = 1; CE_N = 1.
  - done[grant] = 1 for exactly one cycle. Go to IDLE; grant clears in IDLE.
- Latency: req high in IDLE -> done pulse WAIT_CYCLES+2 cycles later. With WAIT_CYCLES=2 that is 4 cycles; back-to-back throughput is 1 access per WAIT_CYCLES+3 cycles.
- Request inputs are sampled only in IDLE; changes during an access are ignored.
- A requester dropping req mid-access still receives done.
- A requester keeping req high after done is re-arbitrated in the next IDLE cycle.
- Simultaneous requests: exactly one grant; losers wait with req held (requests are level).
- Address is not incremented here; requesters own their addressing.
- SRAM_ADDR keeps its last value in IDLE.
- At no time are WE_N = 0 and OE_N = 0 together.
- SRAM_DQ_OE = 1 only during write SETUP/ACCESS/DONE.

Optional Feature:
- Macro SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration; a last-grant pointer is updated at DONE.
  - The search starts at last+1 modulo NUM_REQ; the pointer resets to NUM_REQ-1, so index 0 wins first.
- Undefined: fixed priority, lowest index wins. The pointer logic is not present.

Decomposition:
- Package sram_arb_pkg:
  - state enum (2 bits: IDLE, SETUP, ACCESS, DONE)
  - constants SRAM_AW=20, SRAM_DW=16
  - requester index localparams REQ_GAME=0, REQ_BG=1, REQ_SPARE=2
- Sub-module sram_arb_select: combinational winner picker (req, last pointer -> one-hot winner) holding the priority/round-robin logic.
- The FSM and strobe generation stay in the top.

Test Plan:
- Reset: Reset_n=0 with strobes low mid-access -> all strobes 1, SRAM_DQ_OE=0, done=0 immediately, without waiting for a clock.
- Single read: req[1]=1, we=0, addr=20'h25801, SRAM model returns 16'h0A0B -> SRAM_ADDR=20'h25801 and OE_N low 3 cycles, done[1] pulse at cycle 4, rdata=16'h0A0B.
- Single write: req[0]=1, we=1, addr=20'h00010, wdata=16'hBEEF -> WE_N low 2 cycles while DQ_OE=1 with data 16'hBEEF, done[0] pulse, model memory[16]=16'hBEEF.
- Contention (fixed): req=3'b111 held -> grant order 0,0,0... while req[0] stays high; drop req[0] -> grant 1.
- Contention (SRAM_ARB_ROUND_ROBIN_EN): req=3'b111 held for 6 accesses -> grant order 0,1,2,0,1,2.
- Withdraw: req[2] pulsed high for 1 cycle in IDLE -> full access completes, done[2] still pulses once, no second access.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the off-chip SRAM arbiter.
package sram_arb_pkg;
   localparam int SRAM_AW   = 20;
   localparam int SRAM_DW   = 16;

   localparam int REQ_GAME  = 0;
   localparam int REQ_BG    = 1;
   localparam int REQ_SPARE = 2;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      DONE
   } state_t;
endpackage

// File: rtl/sram_arb_select.sv
// Combinational winner picker: fixed priority (lowest index), or round-robin
// from last+1 when SRAM_ARB_ROUND_ROBIN_EN is defined.
module sram_arb_select
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
`ifdef SRAM_ARB_ROUND_ROBIN_EN
   input  logic [IW-1:0]      last_i,
`endif
   output logic [NUM_REQ-1:0] win_o,
   output logic [IW-1:0]      idx_o
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic found;

   always_comb begin
      win_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!found && req_i[(int'(last_i) + i) % NUM_REQ]) begin
            found = 1'b1;
            win_o[(int'(last_i) + i) % NUM_REQ] = 1'b1;
            idx_o = IW'((int'(last_i) + i) % NUM_REQ);
         end
      end
   end
`else
   // Scan high to low so the lowest requesting index is the last to overwrite.
   always_comb begin
      win_o = '0;
      idx_o = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            win_o    = '0;
            win_o[i] = 1'b1;
            idx_o    = IW'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async 16-bit SRAM among NUM_REQ requesters; done pulses WAIT_CYCLES+2
// cycles after req is seen in IDLE. Losers simply hold req. Optional SRAM_ARB_ROUND_ROBIN_EN.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         we,
   input  logic [NUM_REQ*SRAM_AW-1:0] addr,
   input  logic [NUM_REQ*SRAM_DW-1:0] wdata,
   output logic [NUM_REQ-1:0]         done,
   output logic [SRAM_DW-1:0]         rdata,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       busy,
   output logic [SRAM_AW-1:0]         SRAM_ADDR,
   output logic [SRAM_DW-1:0]         Data_to_SRAM,
   input  logic [SRAM_DW-1:0]         Data_from_SRAM,
   output logic                       SRAM_DQ_OE,
   output logic                       SRAM_CE_N,
   output logic                       SRAM_OE_N,
   output logic                       SRAM_WE_N,
   output logic                       SRAM_UB_N,
   output logic                       SRAM_LB_N
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t               state_q;
   logic [2:0]           cnt_q;
   logic                 we_q;
   logic [NUM_REQ-1:0]   grant_q, done_q;
   logic                 busy_q, dq_oe_q;
   logic [SRAM_AW-1:0]   addr_q;
   logic [SRAM_DW-1:0]   wdat_q, rdata_q;
   logic                 ce_n_q, oe_n_q, we_n_q, bs_n_q;
   logic [NUM_REQ-1:0]   win;
   logic [IW-1:0]        win_idx;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic [IW-1:0]        idx_q, last_q;
`endif

   sram_arb_select #(.NUM_REQ(NUM_REQ), .IW(IW)) u_sel (
      .req_i  (req),
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      .last_i (last_q),
`endif
      .win_o  (win),
      .idx_o  (win_idx)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         dq_oe_q <= 1'b0;
         addr_q  <= '0;
         wdat_q  <= '0;
         rdata_q <= '0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         bs_n_q  <= 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         idx_q   <= '0;
         last_q  <= IW'(NUM_REQ - 1);
`endif
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (|req) begin
                  state_q <= SETUP;
                  grant_q <= win;
                  we_q    <= we[win_idx];
                  addr_q  <= addr[win_idx*SRAM_AW +: SRAM_AW];
                  wdat_q  <= wdata[win_idx*SRAM_DW +: SRAM_DW];
                  busy_q  <= 1'b1;
                  ce_n_q  <= 1'b0;
                  bs_n_q  <= 1'b0;
                  oe_n_q  <= we[win_idx];
                  dq_oe_q <= we[win_idx];
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                  idx_q   <= win_idx;
`endif
               end
            end
            SETUP: begin
               state_q <= ACCESS;
               cnt_q   <= 3'(WAIT_CYCLES - 1);
               we_n_q  <= !we_q;
            end
            ACCESS: begin
               if (cnt_q == 3'd0) begin
                  // Strobes release together; write data stays on the pad through DONE.
                  state_q <= DONE;
                  ce_n_q  <= 1'b1;
                  bs_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  we_n_q  <= 1'b1;
                  done_q  <= grant_q;
                  if (!we_q) rdata_q <= Data_from_SRAM;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
               dq_oe_q <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
               last_q  <= idx_q;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign done         = done_q;
   assign rdata        = rdata_q;
   assign grant        = grant_q;
   assign busy         = busy_q;
   assign SRAM_ADDR    = addr_q;
   assign Data_to_SRAM = wdat_q;
   assign SRAM_DQ_OE   = dq_oe_q;
   assign SRAM_CE_N    = ce_n_q;
   assign SRAM_OE_N    = oe_n_q;
   assign SRAM_WE_N    = we_n_q;
   assign SRAM_UB_N    = bs_n_q;
   assign SRAM_LB_N    = bs_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural async SRAM model.
module tb_sram_arbiter;
   localparam int NR = 3;

   logic            Clk = 1'b0;
   logic            Reset_n = 1'b1;
   logic [NR-1:0]   req = '0, we = '0;
   logic [NR*20-1:0] addr = '0;
   logic [NR*16-1:0] wdata = '0;
   logic [NR-1:0]   done, grant;
   logic [15:0]     rdata, Data_to_SRAM;
   logic [15:0]     Data_from_SRAM = '0;
   logic            busy, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
   logic [19:0]     SRAM_ADDR;

   sram_arbiter #(.NUM_REQ(NR), .WAIT_CYCLES(2)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .done(done), .rdata(rdata), .grant(grant), .busy(busy), .SRAM_ADDR(SRAM_ADDR),
      .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM), .SRAM_DQ_OE(SRAM_DQ_OE),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [2:0]  dn;
      logic        rd;
      logic [15:0] rdat;
      logic [19:0] adr;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] mem [logic [19:0]];
   logic [15:0] exp_wdata = '0;
   int checks = 0, failures = 0;
   int cyc = 0, n_done = 0, last_done_cyc = 0;
   int oe_run = 0, we_run = 0, we_ok_run = 0, dq_run = 0, overlap = 0;
   int c0, base;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rd_mem(input logic [19:0] a);
      return mem.exists(a) ? mem[a] : 16'hFFFF;
   endfunction

   initial forever begin
      @(posedge Clk);
      cyc++;
   end

   // SRAM model plus done monitor; everything sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_OE) mem[SRAM_ADDR] = Data_to_SRAM;
         Data_from_SRAM = (!SRAM_CE_N && !SRAM_OE_N) ? rd_mem(SRAM_ADDR) : 16'h0000;
         if (!SRAM_OE_N) oe_run++;
         if (!SRAM_WE_N) we_run++;
         if (!SRAM_WE_N && SRAM_DQ_OE && Data_to_SRAM == exp_wdata) we_ok_run++;
         if (SRAM_DQ_OE) dq_run++;
         if (!SRAM_WE_N && !SRAM_OE_N) overlap++;
         if (done != '0) begin
            n_done++;
            last_done_cyc = cyc;
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=%b required=none", done);
            end else begin
               e = sbq.pop_front();
               chk("done_vec", 32'(done), 32'(e.dn));
               chk("done_addr", 32'(SRAM_ADDR), 32'(e.adr));
               if (e.rd) chk("rdata", 32'(rdata), 32'(e.rdat));
            end
         end
      end
   end

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (n_done < target && n < budget) begin
         @(posedge Clk);
         n++;
      end
      chk("done_timeout", 32'(n_done >= target), 32'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ce_n"}, 32'(SRAM_CE_N), 32'd1);
      chk({tag, "_oe_n"}, 32'(SRAM_OE_N), 32'd1);
      chk({tag, "_we_n"}, 32'(SRAM_WE_N), 32'd1);
      chk({tag, "_ub_lb_n"}, 32'({SRAM_UB_N, SRAM_LB_N}), 32'd3);
      chk({tag, "_dq_oe"}, 32'(SRAM_DQ_OE), 32'd0);
      chk({tag, "_done_grant_busy"}, 32'({done, grant, busy}), 32'd0);
      chk({tag, "_addr"}, 32'(SRAM_ADDR), 32'd0);
      chk({tag, "_rdata_wdata"}, 32'({rdata, Data_to_SRAM}), 32'd0);
   endtask

   task automatic reset_counters();
      oe_run = 0; we_run = 0; we_ok_run = 0; dq_run = 0;
   endtask

   initial begin
      mem[20'h25801] = 16'h0A0B;
      mem[20'h00100] = 16'h1111;
      mem[20'h00200] = 16'h2222;
      mem[20'h00300] = 16'h3333;

      #1 Reset_n = 1'b0;
      #2 chk_reset("por");
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;

      // Single read from the background loader.
      @(posedge Clk); #1;
      reset_counters();
      c0 = cyc;
      we[1] = 1'b0; addr[20 +: 20] = 20'h25801; req[1] = 1'b1;
      sbq.push_back('{dn: 3'b010, rd: 1'b1, rdat: 16'h0A0B, adr: 20'h25801});
      @(posedge Clk); #1 req[1] = 1'b0;
      wait_done(1, 20);
      chk("rd_latency", 32'(last_done_cyc - c0), 32'd4);
      #1;
      chk("rd_oe_low_cycles", 32'(oe_run), 32'd3);
      chk("rd_dq_oe_cycles", 32'(dq_run), 32'd0);
      chk("rd_busy_after", 32'(busy), 32'd0);

      // Single write from game logic.
      reset_counters();
      c0 = cyc;
      exp_wdata = 16'hBEEF;
      we[0] = 1'b1; addr[0 +: 20] = 20'h00010; wdata[0 +: 16] = 16'hBEEF; req[0] = 1'b1;
      sbq.push_back('{dn: 3'b001, rd: 1'b0, rdat: 16'h0000, adr: 20'h00010});
      @(posedge Clk); #1 req[0] = 1'b0;
      wait_done(2, 20);
      chk("wr_latency", 32'(last_done_cyc - c0), 32'd4);
      #1;
      chk("wr_we_low_cycles", 32'(we_run), 32'd2);
      chk("wr_we_low_with_data", 32'(we_ok_run), 32'd2);
      chk("wr_dq_oe_cycles", 32'(dq_run), 32'd4);
      chk("wr_mem16", 32'(rd_mem(20'h00010)), 32'h0000BEEF);

      // Reset in the middle of a write: no done, strobes release immediately.
      we[1] = 1'b1; addr[20 +: 20] = 20'h00020; wdata[16 +: 16] = 16'h1234; req[1] = 1'b1;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      chk("mid_ce_n_low", 32'(SRAM_CE_N), 32'd0);
      req = '0;
      Reset_n = 1'b0;
      #1 chk_reset("mid");
      @(posedge Clk); #1 Reset_n = 1'b1;

      // Contention, all three reading their own address.
      we = '0;
      addr = {20'h00300, 20'h00200, 20'h00100};
      @(posedge Clk); #1;
      base = n_done;
      req = 3'b111;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < 2; k++) begin
         sbq.push_back('{dn: 3'b001, rd: 1'b1, rdat: 16'h1111, adr: 20'h00100});
         sbq.push_back('{dn: 3'b010, rd: 1'b1, rdat: 16'h2222, adr: 20'h00200});
         sbq.push_back('{dn: 3'b100, rd: 1'b1, rdat: 16'h3333, adr: 20'h00300});
      end
      wait_done(base + 6, 60);
      #1 req = '0;
`else
      for (int k = 0; k < 3; k++)
         sbq.push_back('{dn: 3'b001, rd: 1'b1, rdat: 16'h1111, adr: 20'h00100});
      wait_done(base + 3, 40);
      #1 req = 3'b110;
      sbq.push_back('{dn: 3'b010, rd: 1'b1, rdat: 16'h2222, adr: 20'h00200});
      wait_done(base + 4, 20);
      #1 req = 3'b100;
      sbq.push_back('{dn: 3'b100, rd: 1'b1, rdat: 16'h3333, adr: 20'h00300});
      wait_done(base + 5, 20);
      #1 req = '0;
`endif

      // One-cycle request pulse from the spare port still completes once.
      repeat (2) @(posedge Clk);
      #1;
      base = n_done;
      req = 3'b100;
      sbq.push_back('{dn: 3'b100, rd: 1'b1, rdat: 16'h3333, adr: 20'h00300});
      @(posedge Clk); #1 req = '0;
      wait_done(base + 1, 20);
      repeat (12) @(posedge Clk);
      #1;
      chk("withdraw_single_done", 32'(n_done - base), 32'd1);
      chk("withdraw_idle", 32'({busy, grant}), 32'd0);

      chk("we_oe_overlap", 32'(overlap), 32'd0);
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
